// File: rtl/raster_pkg.sv
// Shared types and constants for the raster front end: fixed-point coordinates,
// tile metadata and the tile scheduler state encoding.
package raster_pkg;

    localparam int FX_INT_BITS  = 12;
    localparam int FX_FRAC_BITS = 4;
    localparam int FX_WIDTH     = FX_INT_BITS + FX_FRAC_BITS;

    localparam int TILE_WIDTH        = 16;
    localparam int TILE_HEIGHT       = 16;
    localparam int TILE_GRID_COLS    = 640 / TILE_WIDTH;
    localparam int TILE_GRID_ROWS    = 480 / TILE_HEIGHT;
    localparam int TILE_COORD_SHIFT  = FX_FRAC_BITS + $clog2(TILE_WIDTH);
    localparam int TILE_IDX_W        = 8;

    typedef logic signed [FX_WIDTH-1:0] fx_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
    } coord_2d_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
        fx_t z;
    } coord_3d_t;

    typedef struct packed {
        logic [3:0]            color;
        logic [3:0]            padding;
        logic [TILE_IDX_W-1:0] tile_y;
        logic [TILE_IDX_W-1:0] tile_x;
    } metadata_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/tri_bbox.sv
// Combinational triangle setup: tile-aligned bounding box clamped to the grid,
// doubled signed area, and the cull decision.
module tri_bbox
    import raster_pkg::*;
#(
    parameter int TILE_COLS  = 40,
    parameter int TILE_ROWS  = 30,
    parameter int TILE_SHIFT = 8
) (
    input  coord_3d_t                    v0,
    input  coord_3d_t                    v1,
    input  coord_3d_t                    v2,
    output logic [TILE_IDX_W-1:0]        min_tx,
    output logic [TILE_IDX_W-1:0]        min_ty,
    output logic [TILE_IDX_W-1:0]        max_tx,
    output logic [TILE_IDX_W-1:0]        max_ty,
    output logic signed [34:0]           area,
    output logic                         cull
);

    localparam logic signed [TILE_IDX_W-1:0] COLS_T    = TILE_IDX_W'(TILE_COLS);
    localparam logic signed [TILE_IDX_W-1:0] ROWS_T    = TILE_IDX_W'(TILE_ROWS);
    localparam logic signed [TILE_IDX_W-1:0] COL_MAX_T = TILE_IDX_W'(TILE_COLS - 1);
    localparam logic signed [TILE_IDX_W-1:0] ROW_MAX_T = TILE_IDX_W'(TILE_ROWS - 1);

    function automatic fx_t min3(input fx_t a, input fx_t b, input fx_t c);
        fx_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic fx_t max3(input fx_t a, input fx_t b, input fx_t c);
        fx_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Arithmetic shift keeps negative coordinates negative so off-left boxes cull.
    function automatic logic signed [TILE_IDX_W-1:0] to_tile(input fx_t c);
        fx_t s;
        s = c >>> TILE_SHIFT;
        return s[TILE_IDX_W-1:0];
    endfunction

    logic signed [TILE_IDX_W-1:0] min_tx_s, min_ty_s, max_tx_s, max_ty_s;
    logic signed [16:0]           dx1, dy1, dx2, dy2;
    logic signed [33:0]           p1, p2;

    assign min_tx_s = to_tile(min3(v0.x, v1.x, v2.x));
    assign max_tx_s = to_tile(max3(v0.x, v1.x, v2.x));
    assign min_ty_s = to_tile(min3(v0.y, v1.y, v2.y));
    assign max_ty_s = to_tile(max3(v0.y, v1.y, v2.y));

    assign dx1  = 17'(v1.x) - 17'(v0.x);
    assign dy1  = 17'(v1.y) - 17'(v0.y);
    assign dx2  = 17'(v2.x) - 17'(v0.x);
    assign dy2  = 17'(v2.y) - 17'(v0.y);
    assign p1   = 34'(dx1) * 34'(dy2);
    assign p2   = 34'(dx2) * 34'(dy1);
    assign area = 35'(p1) - 35'(p2);

    assign cull = (area == '0) || max_tx_s[TILE_IDX_W-1] || max_ty_s[TILE_IDX_W-1] ||
                  (min_tx_s >= COLS_T) || (min_ty_s >= ROWS_T);

    assign min_tx = min_tx_s[TILE_IDX_W-1] ? '0 : min_tx_s;
    assign min_ty = min_ty_s[TILE_IDX_W-1] ? '0 : min_ty_s;
    assign max_tx = (max_tx_s > COL_MAX_T) ? COL_MAX_T : max_tx_s;
    assign max_ty = (max_ty_s > ROW_MAX_T) ? ROW_MAX_T : max_ty_s;

endmodule

// File: rtl/tri_tile_scheduler.sv
// Accepts one triangle, culls or bounds it, then walks its tile box row-major
// issuing one valid/ready request per tile to the raster engine.
module tri_tile_scheduler
    import raster_pkg::*;
#(
    parameter int TILE_COLS  = 40,
    parameter int TILE_ROWS  = 30,
    parameter int TILE_SHIFT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    output logic         rdy_in,
    input  coord_3d_t    v0,
    input  coord_3d_t    v1,
    input  coord_3d_t    v2,
    input  logic [3:0]   color_in,
    output logic         vld_out,
    input  logic         rdy_out,
    output coord_3d_t    v0_out,
    output coord_3d_t    v1_out,
    output coord_3d_t    v2_out,
    output metadata_t    metadata_out,
    output logic         tri_done,
    output logic         tri_culled,
    output sched_state_t dbg_state
);

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; once raised, vld_out and its payload hold until that edge.

    sched_state_t          state_q, state_d;
    coord_3d_t             v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [3:0]            color_q, color_d;
    logic [TILE_IDX_W-1:0] min_tx_q, min_tx_d, max_tx_q, max_tx_d, max_ty_q, max_ty_d;
    logic [TILE_IDX_W-1:0] cur_tx_q, cur_tx_d, cur_ty_q, cur_ty_d;
    logic                  done_q, done_d, culled_q, culled_d;

    logic [TILE_IDX_W-1:0] bb_min_tx, bb_min_ty, bb_max_tx, bb_max_ty;
    logic signed [34:0]    bb_area;
    logic                  bb_cull;

    tri_bbox #(
        .TILE_COLS  (TILE_COLS),
        .TILE_ROWS  (TILE_ROWS),
        .TILE_SHIFT (TILE_SHIFT)
    ) u_bbox (
        .v0     (v0_q),
        .v1     (v1_q),
        .v2     (v2_q),
        .min_tx (bb_min_tx),
        .min_ty (bb_min_ty),
        .max_tx (bb_max_tx),
        .max_ty (bb_max_ty),
        .area   (bb_area),
        .cull   (bb_cull)
    );

    always_comb begin
        state_d  = state_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        color_d  = color_q;
        min_tx_d = min_tx_q;
        max_tx_d = max_tx_q;
        max_ty_d = max_ty_q;
        cur_tx_d = cur_tx_q;
        cur_ty_d = cur_ty_q;
        done_d   = 1'b0;
        culled_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (vld_in) begin
                    v0_d    = v0;
                    v1_d    = v1;
                    v2_d    = v2;
                    color_d = color_in;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bb_cull) begin
                    culled_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    min_tx_d = bb_min_tx;
                    max_tx_d = bb_max_tx;
                    max_ty_d = bb_max_ty;
                    cur_tx_d = bb_min_tx;
                    cur_ty_d = bb_min_ty;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rdy_out) begin
                    if (cur_tx_q == max_tx_q && cur_ty_q == max_ty_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cur_tx_q < max_tx_q) begin
                        cur_tx_d = cur_tx_q + 1'b1;
                    end else begin
                        cur_tx_d = min_tx_q;
                        cur_ty_d = cur_ty_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            v0_q     <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            color_q  <= '0;
            min_tx_q <= '0;
            max_tx_q <= '0;
            max_ty_q <= '0;
            cur_tx_q <= '0;
            cur_ty_q <= '0;
            done_q   <= 1'b0;
            culled_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            color_q  <= color_d;
            min_tx_q <= min_tx_d;
            max_tx_q <= max_tx_d;
            max_ty_q <= max_ty_d;
            cur_tx_q <= cur_tx_d;
            cur_ty_q <= cur_ty_d;
            done_q   <= done_d;
            culled_q <= culled_d;
        end
    end

    always_comb begin
        metadata_out         = '0;
        metadata_out.color   = color_q;
        metadata_out.tile_y  = cur_ty_q;
        metadata_out.tile_x  = cur_tx_q;
    end

    assign rdy_in     = (state_q == ST_IDLE);
    assign vld_out    = (state_q == ST_ISSUE);
    assign v0_out     = v0_q;
    assign v1_out     = v1_q;
    assign v2_out     = v2_q;
    assign tri_done   = done_q;
    assign tri_culled = culled_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/tri_tile_scheduler.md
# tri_tile_scheduler

Front-end sequencer for the `raster` tile engine.
- Accepts one screen-space triangle at a time and computes its tile-aligned bounding box, clamped to the 40×30 tile grid.
- Culls triangles that are degenerate or entirely off-screen.
- Issues every tile in the bounding box to the tile engine, one valid/ready transfer per tile, in row-major order.
- Sits between the vertex/setup stage and `raster`.

## Interface
Parameters:
- `TILE_COLS`, 40, tile grid width (640/16).
- `TILE_ROWS`, 30, tile grid height (480/16).
- `TILE_SHIFT`, 8, right-shift from fixed-point coordinate to tile index (`FX_FRAC_BITS` + log2(`TILE_WIDTH`)).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `vld_in`  in  1  triangle valid.
- `rdy_in`  out  1  scheduler can accept a triangle.
- `v0`, `v1`, `v2`  in  `coord_3d_t` (48 each)  vertices, signed 12.4 fixed point.
- `color_in`  in  4  triangle color.
- `vld_out`  out  1  tile request valid to `raster`.
- `rdy_out`  in  1  `raster` ready.
- `v0_out`, `v1_out`, `v2_out`  out  `coord_3d_t`  registered copies of the accepted vertices.
- `metadata_out`  out  `metadata_t`  {color, padding=0, tile_y, tile_x}.
- `tri_done`  out  1  one-cycle pulse: the last tile of the triangle was accepted.
- `tri_culled`  out  1  one-cycle pulse: the triangle was dropped.

## Operation
- States are IDLE, SETUP, ISSUE.
- IDLE:
  - `rdy_in`=1.
  - On `vld_in && rdy_in`: register vertices and color, then go to SETUP.
- SETUP, one cycle:
  - Tile bounds: minimum/maximum of x and y over the three vertices, arithmetic-shifted right by `TILE_SHIFT`.
  - Area: 2× signed area, 35-bit, = (v1.x−v0.x)(v2.y−v0.y) − (v2.x−v0.x)(v1.y−v0.y). Differences are 17-bit signed.
  - Cull the triangle if the area is 0, or max_tx<0, or max_ty<0, or min_tx≥`TILE_COLS`, or min_ty≥`TILE_ROWS`.
  - On cull: pulse `tri_culled` and go to IDLE.
  - Otherwise: clamp min_tx/min_ty to ≥0 and max_tx/max_ty to `TILE_COLS`−1/`TILE_ROWS`−1. Set cur_tx=min_tx and cur_ty=min_ty, then go to ISSUE.
- ISSUE:
  - `vld_out`=1 with `metadata_out`.tile_x=cur_tx, tile_y=cur_ty.
  - On `vld_out && rdy_out`, advance: if cur_tx<max_tx, cur_tx+1. Else cur_tx=min_tx and cur_ty+1.
  - On the transfer at (max_tx, max_ty): pulse `tri_done` and go to IDLE.
- Winding is not checked; both orientations are issued.

## Timing
- Reset values:
  - `rdy_in`=1; `vld_out`=0; `tri_done`=0; `tri_culled`=0.
  - `v*_out`=0; `metadata_out`=0; state=IDLE.
- Latency: triangle accepted at edge N → SETUP in cycle N+1 → first `vld_out` in cycle N+2.
- Cull pulse: `tri_culled` is high in cycle N+2. `rdy_in` returns to 1 in the same cycle.
- `rdy_in` is 0 from the cycle after acceptance until the cycle after the final tile transfer or the cull. There is no overlap between triangles.
- Backpressure: while `vld_out && !rdy_out`, all outputs hold stable. `vld_out` never drops without a transfer.
- Throughput: one tile per cycle when `rdy_out`=1 continuously.
- `tri_done` is asserted in the cycle after the final transfer; state is IDLE in that same cycle.
- A single-tile box issues exactly one request.
- `rst` asserted in any state: the next cycle is IDLE with the reset values. An in-flight triangle is discarded and no pulses are emitted.

## Structure
- Shared package `raster_pkg`:
  - Types `coord_3d_t`, `coord_2d_t`, `metadata_t`.
  - `FX_*` and `TILE_*` constants.
  - A new `sched_state_t` enum.
- One natural sub-module, `tri_bbox`: purely combinational min/max, shift, clamp, cull and area. It is instantiated in SETUP.

## Test plan
- Single tile: vertices at pixels (1,1), (10,1), (1,10), i.e. 0x0010/0x00A0, color 5, `rdy_out`=1 → one transfer with tile (0,0) and color 5, `tri_done` in the next cycle.
- 2×2 span: x,y over pixels 8..24 (0x0080..0x0180), `rdy_out` toggling 1,0,0,1,… → tiles (0,0),(1,0),(0,1),(1,1) in order, outputs stable while stalled, exactly 4 transfers.
- Negative clamp: v0=(−32 px, −32 px) = 0xFE00, v1=(20,0), v2=(0,20) px → tiles (0,0),(1,0),(0,1),(1,1), nothing with a negative index.
- Off-screen and degenerate: all x ≥ 640 px → `tri_culled` at N+2 and no `vld_out`. Collinear (0,0),(5,5),(10,10) px → `tri_culled`.
- Reset mid-issue: full-screen triangle, assert `rst` after 7 transfers → next cycle `vld_out`=0, `rdy_in`=1, no `tri_done`. A new triangle then starts cleanly at its own minimum tile.
